// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: grants one requester at a time and forwards its beats
// to a shared sink until the requester marks the final beat or MAX_BEATS is reached.
module rr_burst_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [NUM_REQ-1:0]        grant_out,
    output logic                      err_overlong
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [7:0]           beat_cnt_q;
    logic                 err_q;

    logic [PTR_W-1:0]     owner_idx;
    logic [PTR_W-1:0]     sel_idx;
    logic [PTR_W-1:0]     ptr_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic                 xfer;

    // Owner index recovered from the one-hot grant; only meaningful while BUSY.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) owner_idx = PTR_W'(i);
        end
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        logic [PTR_W-1:0] above_idx;
        logic [PTR_W-1:0] low_idx;
        logic             above_found;
        above_idx   = '0;
        low_idx     = '0;
        above_found = 1'b0;
        // Descending scan: the last hit written is the lowest index.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                low_idx = PTR_W'(i);
                if (i >= int'(ptr_q)) begin
                    above_idx   = PTR_W'(i);
                    above_found = 1'b1;
                end
            end
        end
        sel_idx = above_found ? above_idx : low_idx;
        grant_d = NUM_REQ'(1) << sel_idx;
        ptr_d   = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        if (state_q == BUSY) begin
            out_valid = req_valid[owner_idx];
            out_data  = req_data[owner_idx*DATA_W +: DATA_W];
            out_last  = req_last[owner_idx] || (beat_cnt_q == 8'(MAX_BEATS - 1));
            req_ready = grant_q & {NUM_REQ{out_ready}};
        end
    end

    assign xfer         = out_valid && out_ready;
    assign grant_out    = grant_q;
    assign err_overlong = err_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q <= grant_d;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        if (out_last) begin
                            state_q    <= IDLE;
                            grant_q    <= '0;
                            beat_cnt_q <= '0;
                            ptr_q      <= ptr_d;
                            err_q      <= !req_last[owner_idx];
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: directed bursts followed by random traffic,
// all compared each cycle against a rotating-priority reference model.
module tb_rr_burst_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic [N-1:0]    grant_out;
    logic            err_overlong;

    always #5 clk = ~clk;

    rr_burst_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .grant_out(grant_out), .err_overlong(err_overlong)
    );

    int total = 0;
    int fails = 0;

    // Directed traffic: remaining beats, burst size (0 = never mark last), position in burst
    int            len[N];
    int            bsz[N];
    int            pos[N];
    logic [DW-1:0] dseq[N];
    bit            gap[N];
    bit            rand_mode;

    // Reference model
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_err;
    logic [N-1:0]  e_grant, e_ready;
    logic          e_valid, e_last;
    logic [DW-1:0] e_data;

    // Observation
    int           glog[$];
    logic [N-1:0] prev_grant;
    int           err_seen;
    int           xfer_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
        prev_grant = '0;
    endtask

    task automatic model_outputs();
        e_grant = '0; e_ready = '0; e_valid = 1'b0; e_last = 1'b0; e_data = '0;
        if (m_busy) begin
            e_grant[m_owner] = 1'b1;
            e_valid = req_valid[m_owner];
            e_data  = req_data[m_owner*DW +: DW];
            e_last  = req_last[m_owner] || (m_cnt == MB - 1);
            if (out_ready) e_ready[m_owner] = 1'b1;
        end
    endtask

    task automatic model_edge();
        bit nerr = 1'b0;
        if (!m_busy) begin
            int p = rr_pick(req_valid);
            if (p >= 0) begin m_busy = 1'b1; m_owner = p; m_cnt = 0; end
        end else if (e_valid && out_ready) begin
            if (e_last) begin
                nerr   = !req_last[m_owner];
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
        m_err = nerr;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rand_mode) begin
                req_valid[i]           = ($urandom_range(0, 9) < 7);
                req_last[i]            = ($urandom_range(0, 3) == 0);
                req_data[i*DW +: DW]   = DW'($urandom);
            end else begin
                req_valid[i]           = (len[i] > 0) && !gap[i];
                req_last[i]            = (bsz[i] > 0) && (pos[i] == bsz[i] - 1);
                req_data[i*DW +: DW]   = dseq[i];
            end
        end
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic step();
        logic [N-1:0] acc;
        drive();
        #1;
        model_outputs();
        check("grant_out",    32'(grant_out),    32'(e_grant));
        check("out_valid",    32'(out_valid),    32'(e_valid));
        check("out_data",     32'(out_data),     32'(e_data));
        check("out_last",     32'(out_last),     32'(e_last));
        check("req_ready",    32'(req_ready),    32'(e_ready));
        check("err_overlong", 32'(err_overlong), 32'(m_err));
        if (grant_out != '0 && prev_grant == '0) glog.push_back(onehot_idx(grant_out));
        prev_grant = grant_out;
        if (err_overlong === 1'b1) err_seen++;
        if (out_valid === 1'b1 && out_ready) xfer_seen++;
        acc = e_ready & req_valid;
        @(posedge clk);
        model_edge();
        if (!rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    len[i]--;
                    dseq[i] = dseq[i] + 8'd1;
                    pos[i]  = (bsz[i] > 0 && pos[i] == bsz[i] - 1) ? 0 : pos[i] + 1;
                end
            end
        end
        #1;
    endtask

    task automatic clear_traffic();
        for (int i = 0; i < N; i++) begin
            len[i] = 0; bsz[i] = 1; pos[i] = 0; gap[i] = 1'b0;
            dseq[i] = DW'(8'h10 * (i + 1));
        end
        glog.delete();
        err_seen  = 0;
        xfer_seen = 0;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0;
        rand_mode = 1'b0;
        clear_traffic();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant_out), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_err",   32'(err_overlong), 32'h0);
        reset = 1'b0;

        // All requesting, two-beat bursts: rotating order from ptr 0
        clear_traffic();
        out_ready = 1'b1;
        len = '{4, 2, 2, 2};
        for (int i = 0; i < N; i++) bsz[i] = 2;
        repeat (17) step();
        check("rr_count", 32'(glog.size()), 32'd5);
        for (int k = 0; k < 5 && k < glog.size(); k++) check("rr_order", 32'(glog[k]), 32'(k % N));
        check("rr_beats", 32'(xfer_seen), 32'd10);

        // Single requester 2, three-beat burst
        clear_traffic();
        len[2] = 3; bsz[2] = 3;
        step();
        check("single_latency", 32'(grant_out), 32'b0100);
        repeat (5) step();
        check("single_beats", 32'(xfer_seen), 32'd3);
        check("single_idle", 32'(grant_out), 32'h0);

        // Wrap from ptr 3; the second grant proves ptr moved to 1
        clear_traffic();
        len[0] = 2; bsz[0] = 1; len[1] = 1; bsz[1] = 1;
        repeat (8) step();
        check("wrap_count", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) begin
            check("wrap_first",  32'(glog[0]), 32'd0);
            check("wrap_second", 32'(glog[1]), 32'd1);
            check("wrap_third",  32'(glog[2]), 32'd0);
        end

        // Overlong burst from requester 1
        clear_traffic();
        len[1] = MB; bsz[1] = 0;
        repeat (MB + 3) step();
        check("overlong_beats", 32'(xfer_seen), 32'(MB));
        check("overlong_pulses", 32'(err_seen), 32'd1);
        check("overlong_idle", 32'(grant_out), 32'h0);

        // Backpressure 1010 and a two-cycle owner gap
        clear_traffic();
        len[2] = 4; bsz[2] = 4;
        for (int k = 0; k < 12; k++) begin
            out_ready = (k % 2 == 0);
            gap[2]    = (k == 3 || k == 4);
            step();
        end
        check("gap_beats", 32'(xfer_seen), 32'd4);
        check("gap_grants", 32'(glog.size()), 32'd1);
        check("gap_err", 32'(err_seen), 32'd0);

        // Reset during beat 2 of a burst
        clear_traffic();
        out_ready = 1'b1;
        len[0] = 4; bsz[0] = 4;
        step();
        step();
        drive();
        #1;
        reset = 1'b1;
        #1;
        check("midrst_grant", 32'(grant_out), 32'h0);
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_data",  32'(out_data),  32'h0);
        check("midrst_last",  32'(out_last),  32'h0);
        check("midrst_ready", 32'(req_ready), 32'h0);
        check("midrst_err",   32'(err_overlong), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_traffic();
        len[3] = 1; bsz[3] = 1;
        step();
        check("postrst_grant", 32'(grant_out), 32'b1000);
        repeat (3) step();
        check("postrst_beats", 32'(xfer_seen), 32'd1);

        // Random traffic against the model
        rand_mode = 1'b1;
        repeat (1500) step();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/rr_burst_arbiter.md
RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning beat data width.
REQ-003 The block SHALL have parameter MAX_BEATS, default 8, meaning the maximum beats per grant before forced release (2..255).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning the asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ, meaning per-requester beat valid.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_W, meaning packed beat data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port req_last, input, NUM_REQ, meaning per-requester final-beat marker.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ, meaning per-requester beat accept.
REQ-010 The block SHALL have port out_valid, output, 1, meaning shared-resource beat valid.
REQ-011 The block SHALL have port out_data, output, DATA_W, meaning shared-resource beat data.
REQ-012 The block SHALL have port out_last, output, 1, meaning shared-resource final beat.
REQ-013 The block SHALL have port out_ready, input, 1, meaning shared-resource accept.
REQ-014 The block SHALL have port grant_out, output, NUM_REQ, meaning the registered one-hot owner; all zero when idle.
REQ-015 The block SHALL have port err_overlong, output, 1, meaning a one-cycle pulse on forced release.

Function
REQ-016 The FSM SHALL have states IDLE and BUSY, plus registers ptr (clog2(NUM_REQ) bits), grant (one-hot) and beat_cnt (8 bits).
REQ-017 In IDLE with any req_valid set, the block SHALL select the lowest index i >= ptr with req_valid[i]; if none exists, it SHALL select the lowest set index; it SHALL register one-hot grant and enter BUSY on the next edge.
REQ-018 In IDLE with req_valid == 0, the block SHALL stay in IDLE with grant 0.
REQ-019 Arbitration latency SHALL be exactly 1 cycle (req_valid seen in IDLE -> grant_out valid next cycle); no beat SHALL transfer in IDLE.
REQ-020 In IDLE, out_valid, out_last and req_ready SHALL be 0, and out_data SHALL be 0.
REQ-021 In BUSY with owner g: out_valid = req_valid[g], out_data = req_data slice g, req_ready[g] = out_ready, other req_ready bits = 0; these paths are combinational.
REQ-022 A beat SHALL transfer when out_valid && out_ready, and each transfer SHALL increment beat_cnt.
REQ-023 out_last SHALL equal req_last[g] OR (beat_cnt == MAX_BEATS-1).
REQ-024 On a transfer with out_last = 1, on the next edge the block SHALL set state = IDLE, grant = 0, beat_cnt = 0 and ptr = (g+1) mod NUM_REQ.
REQ-025 If that release was forced (req_last[g] = 0), err_overlong SHALL be 1 for exactly the following cycle.
REQ-026 Owner deasserting req_valid mid-burst SHALL NOT release the grant; the block SHALL wait indefinitely.
REQ-027 Changes on non-owner req_valid while BUSY SHALL have no effect.
REQ-028 After a release there SHALL be at least one IDLE cycle before the next grant (max throughput: MAX_BEATS beats per MAX_BEATS+1 cycles).
REQ-029 A single-beat burst (req_last on the first beat) SHALL release after one transfer.
REQ-030 ptr wrap-around SHALL give NUM_REQ-1 -> 0.
REQ-031 A requester continuously requesting SHALL be granted within NUM_REQ arbitration rounds.

Reset
REQ-032 On reset asserted, asynchronously: state = IDLE, ptr = 0, grant_out = 0, beat_cnt = 0, err_overlong = 0; hence out_valid = 0, out_last = 0, out_data = 0, req_ready = 0.
REQ-033 Reset asserted mid-burst SHALL abandon the burst immediately, with no beat accepted in that cycle and no err_overlong.
REQ-034 First arbitration after reset deassertion SHALL use ptr = 0.

Verification
REQ-035 Single requester: req_valid = 4'b0100, 3-beat burst, last on beat 3, out_ready = 1 -> grant_out = 4'b0100 one cycle later; 3 transfers; IDLE; next ptr = 3.
REQ-036 All requesting, 2-beat bursts each, out_ready = 1 -> grant order 0,1,2,3,0; one idle cycle between bursts.
REQ-037 Wrap: ptr = 3, req_valid = 4'b0011 -> grant 4'b0001; ptr becomes 1 after release.
REQ-038 Overlong: requester 1 never asserts req_last, MAX_BEATS = 8 -> out_last on the 8th beat; release; err_overlong high exactly one cycle.
REQ-039 Backpressure and gaps: out_ready toggled 1010 and the owner drops req_valid for 2 cycles mid-burst -> grant held, beat_cnt counts only accepted beats, data order intact.
REQ-040 Reset asserted during beat 2 of a burst -> all outputs 0 immediately; after release, req_valid = 4'b1000 is granted with ptr = 0 semantics.
